// File: rtl/line_mirror_pkg.sv
// Shared defaults and constants for the line_mirror horizontal-flip stage.
package line_mirror_pkg;

  localparam int DEF_MAX_H = 1920;
  localparam int DEF_DW    = 8;
  localparam int DEF_FILL  = 0;
  localparam int SYNC_DLY  = 2;

  function automatic int addr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/line_mirror_bank.sv
// One line bank: synchronous write, registered read, MAX_H x 3*DW.
module line_mirror_bank #(
  parameter int DEPTH = 1920,
  parameter int W     = 24,
  parameter int AW    = 11
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto block RAM; stale contents are masked by the valid flags.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/line_mirror.sv
// Ping-pong line buffer that emits each active line reversed, one line late; sync lags 2 clk.
// Build with LINE_MIRROR_CTRL_EN to add mirror_en, which selects mirrored or straight line delay.
module line_mirror
  import line_mirror_pkg::*;
#(
  parameter int MAX_H = DEF_MAX_H,
  parameter int DW    = DEF_DW,
  parameter int FILL  = DEF_FILL,
  parameter int AW    = $clog2(MAX_H + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vs_in,
  input  logic          hs_in,
  input  logic          de_in,
`ifdef LINE_MIRROR_CTRL_EN
  input  logic          mirror_en,
`endif
  input  logic [DW-1:0] r_in,
  input  logic [DW-1:0] g_in,
  input  logic [DW-1:0] b_in,
  output logic          vs_out,
  output logic          hs_out,
  output logic          de_out,
  output logic [DW-1:0] r_out,
  output logic [DW-1:0] g_out,
  output logic [DW-1:0] b_out,
  output logic          ovf_err
);

  localparam int              BAW     = addr_bits(MAX_H);
  localparam int              PW      = 3 * DW;
  localparam logic [AW-1:0]   MAX_CNT = AW'(MAX_H);
  localparam logic [DW-1:0]   FILL_CH = DW'(FILL);

  logic [SYNC_DLY-1:0] vs_sr, hs_sr, de_sr;
  logic                de_d1;
  logic                wr_bank;
  logic [AW-1:0]       wr_cnt, rd_cnt;
  logic [1:0][AW-1:0]  len;
  logic [1:0]          valid;
  logic                full, rb, hit, mirror_now;
  logic [AW-1:0]       rd_addr;
  logic                fill_q, rb_q;
  logic [PW-1:0]       wdata, rdata0, rdata1, rdata_sel;

  assign de_d1 = de_sr[0];
  assign full  = (wr_cnt == MAX_CNT);
  assign rb    = ~wr_bank;
  assign wdata = {r_in, g_in, b_in};

`ifdef LINE_MIRROR_CTRL_EN
  logic mirror_q;

  // The first pixel of a line must already see the newly sampled mode.
  assign mirror_now = (de_in & ~de_d1) ? mirror_en : mirror_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                mirror_q <= 1'b1;
    else if (de_in & ~de_d1) mirror_q <= mirror_en;
  end
`else
  assign mirror_now = 1'b1;
`endif

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    hit     = 1'b0;
    rd_addr = rd_cnt;
    if (valid[rb] && (rd_cnt < len[rb])) hit = 1'b1;
    if (mirror_now) rd_addr = len[rb] - AW'(1) - rd_cnt;
  end

  line_mirror_bank #(.DEPTH(MAX_H), .W(PW), .AW(BAW)) u_bank0 (
    .clk   (clk),
    .we    (de_in & ~wr_bank & ~full),
    .waddr (wr_cnt[BAW-1:0]),
    .wdata (wdata),
    .raddr (rd_addr[BAW-1:0]),
    .rdata (rdata0)
  );

  line_mirror_bank #(.DEPTH(MAX_H), .W(PW), .AW(BAW)) u_bank1 (
    .clk   (clk),
    .we    (de_in & wr_bank & ~full),
    .waddr (wr_cnt[BAW-1:0]),
    .wdata (wdata),
    .raddr (rd_addr[BAW-1:0]),
    .rdata (rdata1)
  );

  // Line bookkeeping; a frame clear overrides end-of-line so partial lines are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank <= 1'b0;
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      len     <= '0;
      valid   <= '0;
      ovf_err <= 1'b0;
    end else if (!vs_in) begin
      wr_bank <= 1'b0;
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      valid   <= '0;
      ovf_err <= 1'b0;
    end else if (de_in) begin
      if (full) ovf_err <= 1'b1;
      else      wr_cnt  <= wr_cnt + AW'(1);
      if (rd_cnt != MAX_CNT) rd_cnt <= rd_cnt + AW'(1);
    end else if (de_d1) begin
      len[wr_bank]   <= wr_cnt;
      valid[wr_bank] <= 1'b1;
      wr_bank        <= ~wr_bank;
      wr_cnt         <= '0;
      rd_cnt         <= '0;
    end
  end

  assign rdata_sel = rb_q ? rdata1 : rdata0;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_sr  <= '1;
      hs_sr  <= '0;
      de_sr  <= '0;
      fill_q <= 1'b1;
      rb_q   <= 1'b0;
      {r_out, g_out, b_out} <= '0;
    end else begin
      vs_sr  <= {vs_sr[SYNC_DLY-2:0], vs_in};
      hs_sr  <= {hs_sr[SYNC_DLY-2:0], hs_in};
      de_sr  <= {de_sr[SYNC_DLY-2:0], de_in};
      fill_q <= ~hit;
      rb_q   <= rb;
      if (de_d1) {r_out, g_out, b_out} <= fill_q ? {3{FILL_CH}} : rdata_sel;
      else       {r_out, g_out, b_out} <= '0;
    end
  end

  assign vs_out = vs_sr[SYNC_DLY-1];
  assign hs_out = hs_sr[SYNC_DLY-1];
  assign de_out = de_sr[SYNC_DLY-1];

endmodule

// File: tb/tb_line_mirror.sv
// Directed bench for line_mirror with MAX_H=8 and a distinctive FILL value.
module tb_line_mirror;

  localparam int MAX_H = 8;
  localparam int DW    = 8;
  localparam int FILL  = 8'hA5;

  logic          clk = 1'b0;
  logic          rst;
  logic          vs_in, hs_in, de_in, mirror_en;
  logic [DW-1:0] r_in, g_in, b_in;
  logic          vs_out, hs_out, de_out, ovf_err;
  logic [DW-1:0] r_out, g_out, b_out;

  int checks   = 0;
  int failures = 0;

  logic [23:0] cap [$];
  logic [31:0] ovf_trace;

  line_mirror #(.MAX_H(MAX_H), .DW(DW), .FILL(FILL)) dut (
`ifdef LINE_MIRROR_CTRL_EN
    .mirror_en (mirror_en),
`endif
    .clk     (clk),
    .rst     (rst),
    .vs_in   (vs_in),
    .hs_in   (hs_in),
    .de_in   (de_in),
    .r_in    (r_in),
    .g_in    (g_in),
    .b_in    (b_in),
    .vs_out  (vs_out),
    .hs_out  (hs_out),
    .de_out  (de_out),
    .r_out   (r_out),
    .g_out   (g_out),
    .b_out   (b_out),
    .ovf_err (ovf_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (de_out === 1'b1) cap.push_back({r_out, g_out, b_out});

  // Pixel encoding for value v; negative v means the FILL pixel.
  function automatic logic [23:0] pix(input int v);
    logic [7:0] c;
    c = v[7:0];
    if (v < 0) return {3{8'hA5}};
    return {c, c ^ 8'h55, ~c};
  endfunction

  function automatic logic [23:0] got(input int i);
    if (i < cap.size()) return cap[i];
    return 'x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame_gap();
    vs_in = 1'b0;
    repeat (3) tick();
    vs_in = 1'b1;
    repeat (2) tick();
  endtask

  task automatic run_line(input int n, input int start, input int step, input int toggle_at);
    cap.delete();
    hs_in = 1'b1;
    tick();
    tick();
    hs_in = 1'b0;
    tick();
    for (int i = 0; i < n; i++) begin
      if (i == toggle_at) mirror_en = ~mirror_en;
      de_in = 1'b1;
      {r_in, g_in, b_in} = pix(start + i * step);
      tick();
      ovf_trace[i] = ovf_err;
    end
    de_in = 1'b0;
    {r_in, g_in, b_in} = '0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    vs_in = 1'b1; hs_in = 1'b1; de_in = 1'b1; mirror_en = 1'b1;
    {r_in, g_in, b_in} = 24'h123456;
    repeat (2) tick();
    checks += 5;
    if (vs_out !== 1'b1) begin failures++; $display("FAIL reset_vs: got %b want 1", vs_out); end
    if (hs_out !== 1'b0) begin failures++; $display("FAIL reset_hs: got %b want 0", hs_out); end
    if (de_out !== 1'b0) begin failures++; $display("FAIL reset_de: got %b want 0", de_out); end
    if ({r_out, g_out, b_out} !== 24'h0) begin failures++; $display("FAIL reset_rgb: got %h want 0", {r_out, g_out, b_out}); end
    if (ovf_err !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %b want 0", ovf_err); end
    hs_in = 1'b0; de_in = 1'b0; {r_in, g_in, b_in} = '0;
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int e [$];
    frame_gap();
    run_line(4, 1, 1, -1);
    e = '{-1, -1, -1, -1};
    checks++;
    if (cap.size() != e.size()) begin failures++; $display("FAIL basic_a_count: got %0d want %0d", cap.size(), e.size()); end
    foreach (e[i]) begin
      checks++;
      if (got(i) !== pix(e[i])) begin failures++; $display("FAIL basic_a[%0d]: got %h want %h", i, got(i), pix(e[i])); end
    end
    run_line(4, 50, 1, -1);
    e = '{4, 3, 2, 1};
    checks++;
    if (cap.size() != e.size()) begin failures++; $display("FAIL basic_b_count: got %0d want %0d", cap.size(), e.size()); end
    foreach (e[i]) begin
      checks++;
      if (got(i) !== pix(e[i])) begin failures++; $display("FAIL basic_b[%0d]: got %h want %h", i, got(i), pix(e[i])); end
    end
  endtask

  task automatic test_sync();
    logic [19:0] vp, hp, dp;
    logic pv, ph, pd;
    vp = 20'b1111_1111_1110_0111_1111;
    hp = 20'b0001_1000_0100_0011_0010;
    dp = 20'b1100_0111_0011_1100_1001;
    pv = vs_in; ph = hs_in; pd = de_in;
    for (int k = 0; k < 20; k++) begin
      vs_in = vp[k]; hs_in = hp[k]; de_in = dp[k];
      {r_in, g_in, b_in} = pix(k + 1);
      tick();
      checks += 4;
      if (vs_out !== pv) begin failures++; $display("FAIL sync_vs[%0d]: got %b want %b", k, vs_out, pv); end
      if (hs_out !== ph) begin failures++; $display("FAIL sync_hs[%0d]: got %b want %b", k, hs_out, ph); end
      if (de_out !== pd) begin failures++; $display("FAIL sync_de[%0d]: got %b want %b", k, de_out, pd); end
      if (!pd && {r_out, g_out, b_out} !== 24'h0) begin
        failures++; $display("FAIL sync_blank[%0d]: got %h want 0", k, {r_out, g_out, b_out});
      end
      pv = vp[k]; ph = hp[k]; pd = dp[k];
    end
    vs_in = 1'b1; hs_in = 1'b0; de_in = 1'b0; {r_in, g_in, b_in} = '0;
    repeat (3) tick();
  endtask

  task automatic test_mismatch();
    int e [$];
    frame_gap();
    run_line(3, 10, 10, -1);
    run_line(5, 40, 1, -1);
    e = '{30, 20, 10, -1, -1};
    checks++;
    if (cap.size() != e.size()) begin failures++; $display("FAIL longer_count: got %0d want %0d", cap.size(), e.size()); end
    foreach (e[i]) begin
      checks++;
      if (got(i) !== pix(e[i])) begin failures++; $display("FAIL longer[%0d]: got %h want %h", i, got(i), pix(e[i])); end
    end
    run_line(2, 60, 1, -1);
    e = '{44, 43};
    checks++;
    if (cap.size() != e.size()) begin failures++; $display("FAIL shorter_count: got %0d want %0d", cap.size(), e.size()); end
    foreach (e[i]) begin
      checks++;
      if (got(i) !== pix(e[i])) begin failures++; $display("FAIL shorter[%0d]: got %h want %h", i, got(i), pix(e[i])); end
    end
  endtask

  task automatic test_overflow();
    int e [$];
    frame_gap();
    run_line(10, 1, 1, -1);
    checks += 2;
    if (ovf_trace[7] !== 1'b0) begin failures++; $display("FAIL ovf_8th: got %b want 0", ovf_trace[7]); end
    if (ovf_trace[8] !== 1'b1) begin failures++; $display("FAIL ovf_9th: got %b want 1", ovf_trace[8]); end
    run_line(10, 100, 1, -1);
    e = '{8, 7, 6, 5, 4, 3, 2, 1, -1, -1};
    checks++;
    if (cap.size() != e.size()) begin failures++; $display("FAIL ovf_next_count: got %0d want %0d", cap.size(), e.size()); end
    foreach (e[i]) begin
      checks++;
      if (got(i) !== pix(e[i])) begin failures++; $display("FAIL ovf_next[%0d]: got %h want %h", i, got(i), pix(e[i])); end
    end
    checks++;
    if (ovf_err !== 1'b1) begin failures++; $display("FAIL ovf_sticky: got %b want 1", ovf_err); end
    vs_in = 1'b0;
    tick();
    checks++;
    if (ovf_err !== 1'b0) begin failures++; $display("FAIL ovf_clear: got %b want 0", ovf_err); end
    vs_in = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_frame_reset();
    int e [$];
    frame_gap();
    run_line(4, 1, 1, -1);
    frame_gap();
    run_line(4, 9, 1, -1);
    e = '{-1, -1, -1, -1};
    checks++;
    if (cap.size() != e.size()) begin failures++; $display("FAIL frame_count: got %0d want %0d", cap.size(), e.size()); end
    foreach (e[i]) begin
      checks++;
      if (got(i) !== pix(e[i])) begin failures++; $display("FAIL frame[%0d]: got %h want %h", i, got(i), pix(e[i])); end
    end
    // Stored line then reset partway through the following one.
    run_line(4, 20, 1, -1);
    hs_in = 1'b1;
    tick();
    hs_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      de_in = 1'b1;
      {r_in, g_in, b_in} = pix(30 + i);
      tick();
    end
    checks++;
    if (de_out !== 1'b1) begin failures++; $display("FAIL pre_rst_de: got %b want 1", de_out); end
    #2 rst = 1'b1;
    #1;
    checks += 4;
    if (vs_out !== 1'b1) begin failures++; $display("FAIL rst_mid_vs: got %b want 1", vs_out); end
    if (de_out !== 1'b0) begin failures++; $display("FAIL rst_mid_de: got %b want 0", de_out); end
    if ({r_out, g_out, b_out} !== 24'h0) begin failures++; $display("FAIL rst_mid_rgb: got %h want 0", {r_out, g_out, b_out}); end
    if (ovf_err !== 1'b0) begin failures++; $display("FAIL rst_mid_ovf: got %b want 0", ovf_err); end
    de_in = 1'b0; {r_in, g_in, b_in} = '0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    run_line(3, 70, 1, -1);
    e = '{-1, -1, -1};
    checks++;
    if (cap.size() != e.size()) begin failures++; $display("FAIL post_rst_count: got %0d want %0d", cap.size(), e.size()); end
    foreach (e[i]) begin
      checks++;
      if (got(i) !== pix(e[i])) begin failures++; $display("FAIL post_rst[%0d]: got %h want %h", i, got(i), pix(e[i])); end
    end
  endtask

`ifdef LINE_MIRROR_CTRL_EN
  task automatic test_ctrl();
    int e [$];
    frame_gap();
    mirror_en = 1'b0;
    run_line(4, 1, 1, -1);
    run_line(4, 20, 1, -1);
    e = '{1, 2, 3, 4};
    checks++;
    if (cap.size() != e.size()) begin failures++; $display("FAIL straight_count: got %0d want %0d", cap.size(), e.size()); end
    foreach (e[i]) begin
      checks++;
      if (got(i) !== pix(e[i])) begin failures++; $display("FAIL straight[%0d]: got %h want %h", i, got(i), pix(e[i])); end
    end
    run_line(4, 40, 1, 2);
    e = '{20, 21, 22, 23};
    checks++;
    if (cap.size() != e.size()) begin failures++; $display("FAIL toggle_count: got %0d want %0d", cap.size(), e.size()); end
    foreach (e[i]) begin
      checks++;
      if (got(i) !== pix(e[i])) begin failures++; $display("FAIL toggle[%0d]: got %h want %h", i, got(i), pix(e[i])); end
    end
    run_line(4, 60, 1, -1);
    e = '{43, 42, 41, 40};
    checks++;
    if (cap.size() != e.size()) begin failures++; $display("FAIL remirror_count: got %0d want %0d", cap.size(), e.size()); end
    foreach (e[i]) begin
      checks++;
      if (got(i) !== pix(e[i])) begin failures++; $display("FAIL remirror[%0d]: got %h want %h", i, got(i), pix(e[i])); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_sync();
    test_mismatch();
    test_overflow();
    test_frame_reset();
`ifdef LINE_MIRROR_CTRL_EN
    test_ctrl();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
